// File: rtl/mrd_fsm_ctrl_pkg.sv
// Shared definitions for the mixed-radix DFT memory engine: frame FSM codes, sample count type, stage limit.
package mrd_fsm_ctrl_pkg;

    localparam int CNT_W      = 12;
    localparam int MAX_STAGES = 6;

    typedef enum logic [2:0] {
        FSM_IDLE        = 3'd0,
        FSM_SINK        = 3'd1,
        FSM_WAIT_TO_RD  = 3'd2,
        FSM_RD          = 3'd3,
        FSM_WAIT_WR_END = 3'd4,
        FSM_SOURCE      = 3'd5
    } fsm_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // An out-of-range factor count would leave the stage loop without an exit.
    function automatic logic [2:0] clamp_factors(input logic [2:0] nf);
        logic [2:0] max_nf;
        max_nf = 3'(MAX_STAGES);
        if (nf == 3'd0) begin
            return 3'd1;
        end
        if (nf > max_nf) begin
            return max_nf;
        end
        return nf;
    endfunction

endpackage

// File: rtl/mrd_fsm_ctrl.sv
// Frame sequencer: Sink -> Wait_to_rd -> (Rd/Wait_wr_end) per radix stage -> Source; one frame in flight.
// Latency: state, stage, err registered; sink_ready registered from next state; source_* decoded from state.
// Backpressure: sink_ready low outside Idle/Sink; Source holds on !source_ready. MRD_FSM_TIMEOUT_EN adds a stage watchdog.
module mrd_fsm_ctrl
    import mrd_fsm_ctrl_pkg::*;
#(
    parameter int wCNT     = CNT_W,
    parameter int WAIT_CYC = 4,
    parameter int TIMEOUT  = 4095
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sink_valid,
    input  logic            sink_sop,
    input  logic            sink_eop,
    output logic            sink_ready,
    input  logic [wCNT-1:0] dftpts,
    input  logic [2:0]      num_factors,
    input  logic            rd_done,
    input  logic            wr_done,
    input  logic            source_ready,
    output logic            source_valid,
    output logic            source_sop,
    output logic            source_eop,
    output logic [wCNT-1:0] source_cnt,
    output logic [2:0]      fsm,
    output logic [2:0]      fsm_r,
    output logic [2:0]      stage,
    output logic            err
);

    localparam logic [wCNT-1:0] ONE      = wCNT'(1);
    localparam logic [wCNT-1:0] WAIT_END = wCNT'(WAIT_CYC - 1);

    if (WAIT_CYC < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mrd_fsm_ctrl: WAIT_CYC and TIMEOUT must be at least 1");
    end

    fsm_e            state, state_nxt;
    logic [wCNT-1:0] len_q, len_nxt;
    logic [2:0]      nf_q, nf_nxt;
    logic [wCNT-1:0] sink_cnt, sink_cnt_nxt;
    logic [wCNT-1:0] src_cnt, src_cnt_nxt;
    logic [wCNT-1:0] wait_cnt, wait_cnt_nxt;
    logic [2:0]      stage_q, stage_nxt;
    logic            wr_seen, wr_seen_nxt;
    logic            err_nxt;
    logic            sink_acc;
    logic [wCNT-1:0] last_idx;
    logic [2:0]      last_stage;

`ifdef MRD_FSM_TIMEOUT_EN
    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
`endif

    assign sink_acc   = sink_valid & sink_ready;
    assign last_idx   = len_q - ONE;
    assign last_stage = nf_q - 3'd1;

    always_comb begin
        state_nxt    = state;
        len_nxt      = len_q;
        nf_nxt       = nf_q;
        sink_cnt_nxt = sink_cnt;
        src_cnt_nxt  = src_cnt;
        wait_cnt_nxt = wait_cnt;
        stage_nxt    = stage_q;
        wr_seen_nxt  = wr_seen;
        err_nxt      = 1'b0;

        case (state)
            FSM_IDLE: begin
                if (sink_acc && sink_sop) begin
                    // A one-sample frame can never satisfy the minimum frame length.
                    if (sink_eop) begin
                        err_nxt = 1'b1;
                    end else begin
                        len_nxt      = dftpts;
                        nf_nxt       = clamp_factors(num_factors);
                        sink_cnt_nxt = ONE;
                        state_nxt    = FSM_SINK;
                    end
                end
            end
            FSM_SINK: begin
                if (sink_acc) begin
                    sink_cnt_nxt = sink_cnt + ONE;
                    if (sink_sop) begin
                        err_nxt      = 1'b1;
                        sink_cnt_nxt = '0;
                        state_nxt    = FSM_IDLE;
                    end else if (sink_cnt == last_idx) begin
                        // Last sample closes the frame even when eop is missing.
                        err_nxt      = ~sink_eop;
                        wait_cnt_nxt = '0;
                        state_nxt    = FSM_WAIT_TO_RD;
                    end else if (sink_eop) begin
                        err_nxt      = 1'b1;
                        sink_cnt_nxt = '0;
                        state_nxt    = FSM_IDLE;
                    end
                end
            end
            FSM_WAIT_TO_RD: begin
                if (wait_cnt == WAIT_END) begin
                    wait_cnt_nxt = '0;
                    stage_nxt    = 3'd0;
                    wr_seen_nxt  = 1'b0;
                    state_nxt    = FSM_RD;
                end else begin
                    wait_cnt_nxt = wait_cnt + ONE;
                end
            end
            FSM_RD: begin
                if (wr_done) begin
                    wr_seen_nxt = 1'b1;
                end
                if (rd_done) begin
                    state_nxt = FSM_WAIT_WR_END;
                end
            end
            FSM_WAIT_WR_END: begin
                if (wr_done || wr_seen) begin
                    wr_seen_nxt = 1'b0;
                    if (stage_q == last_stage) begin
                        src_cnt_nxt = '0;
                        state_nxt   = FSM_SOURCE;
                    end else begin
                        stage_nxt = stage_q + 3'd1;
                        state_nxt = FSM_RD;
                    end
                end
            end
            FSM_SOURCE: begin
                if (source_ready) begin
                    if (src_cnt == last_idx) begin
                        src_cnt_nxt  = '0;
                        sink_cnt_nxt = '0;
                        stage_nxt    = 3'd0;
                        state_nxt    = FSM_IDLE;
                    end else begin
                        src_cnt_nxt = src_cnt + ONE;
                    end
                end
            end
            default: begin
                state_nxt = FSM_IDLE;
            end
        endcase

`ifdef MRD_FSM_TIMEOUT_EN
        // Any stage progress or a write-back report restarts the watchdog.
        wd_cnt_nxt = '0;
        if ((state == FSM_RD || state == FSM_WAIT_WR_END) && state_nxt == state && !wr_done) begin
            if (wd_cnt == WD_END) begin
                err_nxt      = 1'b1;
                state_nxt    = FSM_IDLE;
                stage_nxt    = 3'd0;
                wr_seen_nxt  = 1'b0;
                sink_cnt_nxt = '0;
            end else begin
                wd_cnt_nxt = wd_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FSM_IDLE;
            fsm_r      <= 3'd0;
            len_q      <= '0;
            nf_q       <= 3'd0;
            sink_cnt   <= '0;
            src_cnt    <= '0;
            wait_cnt   <= '0;
            stage_q    <= 3'd0;
            wr_seen    <= 1'b0;
            err        <= 1'b0;
            sink_ready <= 1'b0;
`ifdef MRD_FSM_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            fsm_r      <= state;
            len_q      <= len_nxt;
            nf_q       <= nf_nxt;
            sink_cnt   <= sink_cnt_nxt;
            src_cnt    <= src_cnt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            stage_q    <= stage_nxt;
            wr_seen    <= wr_seen_nxt;
            err        <= err_nxt;
            sink_ready <= (state_nxt == FSM_IDLE) || (state_nxt == FSM_SINK);
`ifdef MRD_FSM_TIMEOUT_EN
            wd_cnt     <= wd_cnt_nxt;
`endif
        end
    end

    assign fsm          = state;
    assign stage        = stage_q;
    assign source_cnt   = src_cnt;
    assign source_valid = (state == FSM_SOURCE);
    assign source_sop   = source_valid && (src_cnt == '0);
    assign source_eop   = source_valid && (src_cnt == last_idx);

endmodule

// File: tb/tb_mrd_fsm_ctrl.sv
// Directed and randomised frames for mrd_fsm_ctrl, checked every cycle against a frame-level model.
module tb_mrd_fsm_ctrl;

    localparam int WCNT = 12;
    localparam int WAIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, sink_valid, sink_sop, sink_eop, sink_ready;
    logic [WCNT-1:0] dftpts;
    logic [2:0]      num_factors;
    logic            rd_done, wr_done, source_ready;
    logic            source_valid, source_sop, source_eop;
    logic [WCNT-1:0] source_cnt;
    logic [2:0]      fsm, fsm_r, stage;
    logic            err;

    mrd_fsm_ctrl #(.wCNT(WCNT), .WAIT_CYC(WAIT), .TIMEOUT(4095)) dut (
        .clk(clk), .rst_n(rst_n),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
        .dftpts(dftpts), .num_factors(num_factors),
        .rd_done(rd_done), .wr_done(wr_done),
        .source_ready(source_ready), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop), .source_cnt(source_cnt),
        .fsm(fsm), .fsm_r(fsm_r), .stage(stage), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { bit sop; bit eop; int len; int nf; } beat_t;
    beat_t beat_q[$];

    int gap_pct = 0, noise_pct = 0, rd_pct = 30, wr_pct = 30, rdy_mode = 2, rdy_pct = 50;
    bit manual = 0, man_rd = 0, man_wr = 0, hold_rst = 1, rand_rst = 0;
    bit drove_beat = 0, rdy_tog = 0;

    // Frame-level model: public phase code plus remaining-work counters.
    int m_fsm = 0, m_fsm_r = 0, m_len = 0, m_nf = 0, m_taken = 0, m_wait_left = 0;
    int m_stage = 0, m_out = 0;
    bit m_wr_pend = 0, m_rdy = 0, m_err = 0;

    int obs_wait = 0, obs_beats = 0, obs_eop_idx = -1, obs_sop_idx = -1, obs_stage_mask = 0, obs_err = 0;

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic bit chance(input int pct);
        return rnd(0, 99) < pct;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_obs();
        obs_wait = 0; obs_beats = 0; obs_eop_idx = -1; obs_sop_idx = -1; obs_stage_mask = 0; obs_err = 0;
    endtask

    task automatic push_frame(input int len, input int nf, input int mode, input int k);
        // mode 0: clean frame, 1: eop on sample k, 2: no eop, 3: second sop at sample k
        int n;
        n = (mode == 1) ? k + 1 : len;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.sop = (i == 0) || (mode == 3 && i == k);
            b.eop = (mode == 0 && i == len - 1) || (mode == 1 && i == k);
            b.len = len;
            b.nf  = nf;
            beat_q.push_back(b);
        end
    endtask

    task automatic drive();
        bit fire;
        fire  = rand_rst && (rnd(0, 599) == 0);
        rst_n = !(hold_rst || fire);
        if (fire) beat_q.delete();
        drove_beat = 0;
        if (beat_q.size() > 0 && rnd(0, 99) >= gap_pct) begin
            sink_valid  = 1'b1;
            sink_sop    = beat_q[0].sop;
            sink_eop    = beat_q[0].eop;
            dftpts      = WCNT'(beat_q[0].len);
            num_factors = 3'(beat_q[0].nf);
            drove_beat  = 1;
        end else begin
            sink_valid  = (m_fsm != 1) && chance(noise_pct);
            sink_sop    = 1'b0;
            sink_eop    = chance(50);
            dftpts      = WCNT'(rnd(12, 1200));
            num_factors = 3'(rnd(0, 7));
        end
        if (manual) begin
            rd_done = man_rd; wr_done = man_wr; man_rd = 0; man_wr = 0;
        end else begin
            rd_done = chance(rd_pct); wr_done = chance(wr_pct);
        end
        case (rdy_mode)
            0:       source_ready = chance(rdy_pct);
            1:       begin rdy_tog = !rdy_tog; source_ready = rdy_tog; end
            default: source_ready = 1'b1;
        endcase
        if (rst_n && source_valid && source_ready) begin
            obs_beats++;
            if (source_sop) obs_sop_idx = int'(source_cnt);
            if (source_eop) obs_eop_idx = int'(source_cnt);
        end
    endtask

    task automatic model_tick();
        bit acc;
        int prev;
        acc  = sink_valid && m_rdy;
        prev = m_fsm;
        if (drove_beat && acc && rst_n) beat_q.delete(0);
        if (!rst_n) begin
            m_fsm = 0; m_fsm_r = 0; m_taken = 0; m_wait_left = 0; m_stage = 0; m_out = 0;
            m_wr_pend = 0; m_rdy = 0; m_err = 0;
            return;
        end
        m_err = 0;
        case (m_fsm)
            0: if (acc && sink_sop) begin
                if (sink_eop) m_err = 1;
                else begin
                    m_len = int'(dftpts); m_nf = int'(num_factors); m_taken = 1; m_fsm = 1;
                end
            end
            1: if (acc) begin
                if (sink_sop) begin
                    m_err = 1; m_fsm = 0;
                end else begin
                    m_taken++;
                    if (m_taken == m_len) begin
                        m_err = !sink_eop; m_fsm = 2; m_wait_left = WAIT;
                    end else if (sink_eop) begin
                        m_err = 1; m_fsm = 0;
                    end
                end
            end
            2: begin
                m_wait_left--;
                if (m_wait_left == 0) begin m_fsm = 3; m_stage = 0; m_wr_pend = 0; end
            end
            3: begin
                if (wr_done) m_wr_pend = 1;
                if (rd_done) m_fsm = 4;
            end
            4: if (wr_done || m_wr_pend) begin
                m_wr_pend = 0;
                if (m_stage + 1 == m_nf) begin m_fsm = 5; m_out = 0; end
                else begin m_stage++; m_fsm = 3; end
            end
            5: if (source_ready) begin
                if (m_out == m_len - 1) begin m_fsm = 0; m_stage = 0; m_out = 0; end
                else m_out++;
            end
            default: m_fsm = 0;
        endcase
        m_fsm_r = prev;
        m_rdy   = (m_fsm == 0) || (m_fsm == 1);
    endtask

    task automatic compare();
        chk("fsm", int'(fsm), m_fsm);
        chk("fsm_r", int'(fsm_r), m_fsm_r);
        chk("stage", int'(stage), m_stage);
        chk("err", int'(err), int'(m_err));
        chk("sink_ready", int'(sink_ready), int'(m_rdy));
        chk("source_valid", int'(source_valid), int'(m_fsm == 5));
        chk("source_sop", int'(source_sop), int'(m_fsm == 5 && m_out == 0));
        chk("source_eop", int'(source_eop), int'(m_fsm == 5 && m_out == m_len - 1));
        chk("source_cnt", int'(source_cnt), m_out);
        if (fsm == 3'd2) obs_wait++;
        if (fsm == 3'd3) obs_stage_mask |= (1 << int'(stage));
        if (err) obs_err++;
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        compare();
    endtask

    task automatic run_to_idle(input string name);
        int cyc;
        cyc = 0;
        while (!(m_fsm == 0 && beat_q.size() == 0) && cyc < 4000) begin
            step();
            cyc++;
        end
        if (cyc >= 4000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no return to Idle within 4000 cycles, fsm=%0d", name, fsm);
            beat_q.delete();
            hold_rst = 1; step(); hold_rst = 0; step();
        end
    endtask

    initial begin
        rst_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        dftpts = '0; num_factors = '0; rd_done = 1'b0; wr_done = 1'b0; source_ready = 1'b0;

        repeat (3) step();
        chk("reset_fsm", int'(fsm), 0);
        chk("reset_sink_ready", int'(sink_ready), 0);
        chk("reset_source_valid", int'(source_valid), 0);
        chk("reset_stage", int'(stage), 0);
        hold_rst = 0;
        step();
        chk("idle_sink_ready", int'(sink_ready), 1);

        // 12-point, 3x4 frame
        clear_obs(); rd_pct = 40; wr_pct = 40;
        push_frame(12, 2, 0, 0);
        run_to_idle("frame12");
        chk("frame12_wait_cycles", obs_wait, 4);
        chk("frame12_src_beats", obs_beats, 12);
        chk("frame12_sop_idx", obs_sop_idx, 0);
        chk("frame12_eop_idx", obs_eop_idx, 11);
        chk("frame12_stages_seen", obs_stage_mask, 3);
        chk("frame12_end_fsm", int'(fsm), 0);

        // eop on the 5th of 12 samples
        push_frame(12, 2, 1, 4);
        repeat (5) step();
        chk("early_eop_err", int'(err), 1);
        chk("early_eop_fsm", int'(fsm), 0);
        chk("early_eop_ready", int'(sink_ready), 1);
        step();
        chk("early_eop_err_cleared", int'(err), 0);

        // wr_done seen in Rd before rd_done, then reset in stage 1
        manual = 1;
        push_frame(12, 3, 0, 0);
        for (int i = 0; i < 200 && m_fsm != 3; i++) step();
        chk("sticky_in_rd", int'(fsm), 3);
        man_wr = 1; step();
        step();
        man_rd = 1; step();
        chk("sticky_wait_wr_end", int'(fsm), 4);
        step();
        chk("sticky_back_to_rd", int'(fsm), 3);
        chk("sticky_stage1", int'(stage), 1);
        hold_rst = 1; step();
        chk("midrst_fsm", int'(fsm), 0);
        chk("midrst_fsm_r", int'(fsm_r), 0);
        chk("midrst_stage", int'(stage), 0);
        chk("midrst_sink_ready", int'(sink_ready), 0);
        chk("midrst_source_valid", int'(source_valid), 0);
        hold_rst = 0; manual = 0; step();

        // source_ready toggling
        clear_obs(); rdy_mode = 1;
        push_frame(12, 1, 0, 0);
        run_to_idle("toggle");
        chk("toggle_src_beats", obs_beats, 12);
        chk("toggle_eop_idx", obs_eop_idx, 11);
        rdy_mode = 2;

        // count reaches dftpts with no eop: frame still processed, one err
        clear_obs();
        push_frame(12, 2, 2, 0);
        run_to_idle("no_eop");
        chk("no_eop_err_pulses", obs_err, 1);
        chk("no_eop_src_beats", obs_beats, 12);

        // second sop mid-frame aborts
        clear_obs();
        push_frame(20, 2, 3, 7);
        run_to_idle("mid_sop");
        chk("mid_sop_err_pulses", obs_err, 1);
        chk("mid_sop_src_beats", obs_beats, 0);

        // randomised traffic
        rand_rst = 1; noise_pct = 10;
        for (int f = 0; f < 24; f++) begin
            int len, mode;
            len       = rnd(12, 48);
            mode      = (f < 4) ? f : (chance(70) ? 0 : rnd(1, 3));
            gap_pct   = rnd(0, 40);
            rd_pct    = rnd(10, 70);
            wr_pct    = rnd(10, 70);
            rdy_mode  = rnd(0, 2);
            rdy_pct   = rnd(20, 90);
            push_frame(len, rnd(1, 6), mode, (mode == 1) ? rnd(1, len - 2) : rnd(1, len - 1));
            run_to_idle("random_frame");
        end
        rand_rst = 0; noise_pct = 0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
